// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing for the 48 MHz reference clock and small elaboration helpers.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    // Defaults for a 48 MHz reference
    localparam int DEF_NUM_PLL             = 2;
    localparam int DEF_PLL_RST_CYCLES      = 48;      // 1 us
    localparam int DEF_LOCK_STABLE_CYCLES  = 4800;    // 100 us
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 480000;  // 10 ms
    localparam int DEF_STAGE_GAP           = 16;
    localparam int DEF_MAX_RETRIES         = 3;

    // retry_count saturates here
    localparam logic [3:0] RETRY_SAT = 4'd15;

    // Largest of four cycle counts, used to size the shared counter
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, with a synchronous
// clear so that a reset forgets any stale lock indication.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Capture the raw inputs, then re-register to settle metastability
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_meta <= {WIDTH{1'b0}};
            r_sync <= {WIDTH{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises NUM_PLL PLLs from the free-running reference clock: pulses their
// RST inputs, waits for lock with timeout and bounded retries, qualifies lock
// stability and then releases the per-domain resets in index order. Any lock
// loss after qualification throws every domain back into reset.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_PLL             = DEF_NUM_PLL,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STAGE_GAP           = DEF_STAGE_GAP,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_PLL-1:0] pll_locked,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [NUM_PLL-1:0] dom_rst,
    output logic               all_locked,
    output logic               fault,
    output logic [3:0]         retry_count
);

    localparam int CNT_MAX = max_of4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES, STAGE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_PLL - 1);
    localparam logic [NUM_PLL-1:0] ALL_ONES   = {NUM_PLL{1'b1}};
    localparam logic [NUM_PLL-1:0] ALL_ZEROS  = {NUM_PLL{1'b0}};

    seq_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_retry;
    logic [NUM_PLL-1:0] r_pll_rst;
    logic [NUM_PLL-1:0] r_dom_rst;
    logic               r_all_locked;
    logic               r_fault;

    logic [NUM_PLL-1:0] w_sync;
    logic               w_lk;
    logic [3:0]         w_retry_inc;
    logic               w_retry_over;

    sync2 #(
        .WIDTH (NUM_PLL)
    ) u_lock_sync (
        .clk   (clk),
        .i_clr (rst),
        .i_d   (pll_locked),
        .o_q   (w_sync)
    );

    // Combined lock flag and the saturating retry increment used on timeout
    always_comb begin
        w_lk = &w_sync;
        if (r_retry == RETRY_SAT) begin
            w_retry_inc = RETRY_SAT;
        end else begin
            w_retry_inc = r_retry + 4'd1;
        end
        if (int'(w_retry_inc) > MAX_RETRIES) begin
            w_retry_over = 1'b1;
        end else begin
            w_retry_over = 1'b0;
        end
    end

    // Sequencer FSM with shared counter, release shifter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_PLLRST;
            r_cnt        <= CNT_ZERO;
            r_idx        <= IDX_ZERO;
            r_retry      <= 4'd0;
            r_pll_rst    <= ALL_ONES;
            r_dom_rst    <= ALL_ONES;
            r_all_locked <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                ST_PLLRST: begin
                    if (r_cnt == PLL_RST_LAST) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_cnt     <= CNT_ZERO;
                        r_pll_rst <= ALL_ZEROS;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes priority over a coincident timeout
                    if (w_lk) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_retry   <= w_retry_inc;
                        r_cnt     <= CNT_ZERO;
                        r_pll_rst <= ALL_ONES;
                        if (w_retry_over) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= ST_PLLRST;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    // A lock dropout restarts qualification without a new PLL pulse
                    if (!w_lk) begin
                        r_cnt <= CNT_ZERO;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state   <= ST_RELEASE;
                        r_cnt     <= CNT_ZERO;
                        r_idx     <= IDX_ZERO;
                        r_dom_rst <= ALL_ONES << 1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_lk) begin
                        r_state   <= ST_PLLRST;
                        r_cnt     <= CNT_ZERO;
                        r_pll_rst <= ALL_ONES;
                        r_dom_rst <= ALL_ONES;
                    end else if (r_idx == IDX_LAST) begin
                        r_state      <= ST_RUN;
                        r_cnt        <= CNT_ZERO;
                        r_dom_rst    <= ALL_ZEROS;
                        r_all_locked <= 1'b1;
                    end else if (r_cnt == GAP_LAST) begin
                        // Released bits fill from index 0 upward
                        r_cnt     <= CNT_ZERO;
                        r_idx     <= r_idx + IDX_ONE;
                        r_dom_rst <= r_dom_rst << 1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // Lock loss is not a timeout, so retry_count is left alone
                    if (!w_lk) begin
                        r_state      <= ST_PLLRST;
                        r_cnt        <= CNT_ZERO;
                        r_pll_rst    <= ALL_ONES;
                        r_dom_rst    <= ALL_ONES;
                        r_all_locked <= 1'b0;
                    end else begin
                        r_all_locked <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Parked until rst: PLLs held in reset, domains held in reset
                    r_pll_rst    <= ALL_ONES;
                    r_dom_rst    <= ALL_ONES;
                    r_all_locked <= 1'b0;
                    r_fault      <= 1'b1;
                end
                default: begin
                    r_state      <= ST_PLLRST;
                    r_cnt        <= CNT_ZERO;
                    r_idx        <= IDX_ZERO;
                    r_pll_rst    <= ALL_ONES;
                    r_dom_rst    <= ALL_ONES;
                    r_all_locked <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = r_pll_rst;
    assign dom_rst     = r_dom_rst;
    assign all_locked  = r_all_locked;
    assign fault       = r_fault;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer. The reference model tracks the
// boot phase and the clock-edge index at which each phase (or the current
// stability window) began; expected outputs are derived from elapsed cycles.
module tb_pll_reset_sequencer;

    localparam int NP = 3;
    localparam int PR = 4;
    localparam int LS = 8;
    localparam int TO = 50;
    localparam int SG = 3;
    localparam int MR = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_QUAL  = 2;
    localparam int PH_REL   = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_PARK  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] pll_locked;
    logic [NP-1:0] pll_rst;
    logic [NP-1:0] dom_rst;
    logic          all_locked;
    logic          fault;
    logic [3:0]    retry_count;

    pll_reset_sequencer #(
        .NUM_PLL             (NP),
        .PLL_RST_CYCLES      (PR),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .STAGE_GAP           (SG),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .dom_rst     (dom_rst),
        .all_locked  (all_locked),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;        // index of the next rising edge
    int last_rst = -100;  // edge index of the most recent rst
    int ph = PH_PULSE;
    int t_entry = 0;      // edge at which the current phase began
    int q_ref = 0;        // edge of last qualification (re)start
    int retries = 0;
    bit hist[$];          // AND of pll_locked seen at each edge

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the reference by one clock edge
    task automatic model_edge(input bit r, input logic [NP-1:0] pl);
        bit lk;
        hist.push_back(&pl);
        if (r) begin
            last_rst = cyc;
            ph = PH_PULSE;
            t_entry = cyc;
            retries = 0;
        end else begin
            // Lock is visible two edges after sampling, and never across a reset
            lk = (cyc - last_rst >= 3) ? hist[cyc-2] : 1'b0;
            case (ph)
                PH_PULSE: if (cyc - t_entry == PR) begin ph = PH_WAIT; t_entry = cyc; end
                PH_WAIT: begin
                    if (lk) begin
                        ph = PH_QUAL; t_entry = cyc; q_ref = cyc;
                    end else if (cyc - t_entry == TO) begin
                        retries = (retries < 15) ? retries + 1 : 15;
                        ph = (retries > MR) ? PH_PARK : PH_PULSE;
                        t_entry = cyc;
                    end
                end
                PH_QUAL: begin
                    if (!lk) q_ref = cyc;
                    else if (cyc - q_ref == LS) begin ph = PH_REL; t_entry = cyc; end
                end
                PH_REL: begin
                    if (!lk) begin ph = PH_PULSE; t_entry = cyc; end
                    else if (cyc - t_entry == (NP - 1) * SG + 1) begin ph = PH_RUN; t_entry = cyc; end
                end
                PH_RUN: if (!lk) begin ph = PH_PULSE; t_entry = cyc; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [NP-1:0] exp_dom();
        logic [NP-1:0] d;
        d = '1;
        if (ph == PH_RUN) d = '0;
        if (ph == PH_REL) begin
            for (int i = 0; i < NP; i++) begin
                if (cyc - t_entry >= i * SG) d[i] = 1'b0;
            end
        end
        return d;
    endfunction

    task automatic step(input bit r, input logic [NP-1:0] pl);
        logic [NP-1:0] ep;
        rst = r;
        pll_locked = pl;
        @(posedge clk);
        model_edge(r, pl);
        #1;
        ep = (ph == PH_PULSE || ph == PH_PARK) ? '1 : '0;
        check_val("pll_rst", 32'(pll_rst), 32'(ep));
        check_val("dom_rst", 32'(dom_rst), 32'(exp_dom()));
        check_val("all_locked", 32'(all_locked), 32'(ph == PH_RUN));
        check_val("fault", 32'(fault), 32'(ph == PH_PARK));
        check_val("retry_count", 32'(retry_count), 32'(retries));
        cyc++;
    endtask

    initial begin
        bit seen;
        bit held;
        int dly;
        int len;
        logic [NP-1:0] pl;

        rst = 1'b1;
        pll_locked = '0;

        // Nominal boot with lock from cycle 10
        step(1'b1, 3'b000);
        check_val("reset_pll_rst", 32'(pll_rst), 32'h7);
        check_val("reset_dom_rst", 32'(dom_rst), 32'h7);
        check_val("reset_retry", 32'(retry_count), 32'h0);
        for (int i = 1; i < 60; i++) step(1'b0, (i >= 10) ? 3'b111 : 3'b000);
        check_val("nominal_run", 32'(all_locked), 32'h1);
        check_val("nominal_dom", 32'(dom_rst), 32'h0);

        // Stability glitch at qualification count 5
        step(1'b1, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (ph == PH_QUAL && cyc == q_ref + 4) begin
                seen = 1'b1;
                step(1'b0, 3'b101);
            end else begin
                step(1'b0, 3'b111);
            end
        end
        check_val("glitch_reached", 32'(seen), 32'h1);
        for (int i = 0; i < 40; i++) step(1'b0, 3'b111);
        check_val("glitch_run", 32'(all_locked), 32'h1);

        // Never locks: three timeouts then parked
        step(1'b1, 3'b000);
        for (int i = 0; i < 250; i++) step(1'b0, 3'b000);
        check_val("nolock_fault", 32'(fault), 32'h1);
        check_val("nolock_retries", 32'(retry_count), 32'h3);
        check_val("nolock_pll_rst", 32'(pll_rst), 32'h7);
        for (int i = 0; i < 10; i++) step(1'b0, 3'b111);
        check_val("fault_sticky", 32'(fault), 32'h1);

        // Lock loss in RUN and relock
        step(1'b1, 3'b000);
        for (int i = 0; i < 40; i++) step(1'b0, 3'b111);
        for (int i = 0; i < 10; i++) step(1'b0, 3'b101);
        for (int i = 0; i < 45; i++) step(1'b0, 3'b111);
        check_val("relock_run", 32'(all_locked), 32'h1);
        check_val("relock_retry", 32'(retry_count), 32'h0);

        // Reset during RELEASE after the first domain is out of reset
        step(1'b1, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(1'b0, 3'b111);
            if (ph == PH_REL && cyc - 1 - t_entry >= 1) seen = 1'b1;
        end
        check_val("midrst_reached", 32'(seen), 32'h1);
        step(1'b1, 3'b111);
        check_val("midrst_pll_rst", 32'(pll_rst), 32'h7);
        check_val("midrst_dom_rst", 32'(dom_rst), 32'h7);
        check_val("midrst_locked", 32'(all_locked), 32'h0);
        for (int i = 0; i < 30; i++) step(1'b0, 3'b111);

        // Lock arriving on the exact timeout edge
        step(1'b1, 3'b000);
        held = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (ph == PH_WAIT && cyc == t_entry + TO - 2) held = 1'b1;
            step(1'b0, held ? 3'b111 : 3'b000);
        end
        check_val("race_armed", 32'(held), 32'h1);
        check_val("race_retry", 32'(retry_count), 32'h0);
        check_val("race_run", 32'(all_locked), 32'h1);

        // Randomised segments
        for (int s = 0; s < 40; s++) begin
            step(1'b1, 3'b000);
            dly = $urandom_range(0, 130);
            len = $urandom_range(80, 300);
            for (int i = 0; i < len; i++) begin
                pl = (i >= dly) ? 3'b111 : NP'($urandom_range(0, 7));
                if ($urandom_range(0, 39) == 0) pl[$urandom_range(0, NP - 1)] = 1'b0;
                step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, pl);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
